io_port_unit: RTL and testbench

- Handles the CPU side of the In (6'b011011) and Out (6'b011100) instructions that the control unit decodes.
- In: stalls the core until an operator presses the debounced "enter" button, then supplies the switch value for register writeback (memoryToRegister select 2).
- Out: latches a register value into the display register.
- Sits between the instruction decode/writeback path and the board switches, button and 7-segment display driver.

---
 rtl/io_port_unit.sv | 185 ++++++++++++++++++
 tb/tb_io_port_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/io_port_unit.sv
// io_port_unit: CPU side of the In/Out instructions (switch input with operator
//   handshake via a debounced enter button, latched 7-segment display value).
// Latency: Out -> displayValue/outStrobe 1 cycle; press pulse -> inWrite 1 cycle;
//   physical button edge -> press pulse DEBOUNCE_CYCLES+2..+3 cycles.
// Backpressure: stall holds the PC on an In (combinationally in the decode cycle,
//   registered while waiting) until the captured value is written back.
//
// Ports:
//   clock, reset (async, active-low)
//   opcode, halt, outData     - decode/operand inputs from the core
//   switches, enterButton     - asynchronous board inputs
//   inData, inWrite           - writeback value and its one-cycle valid
//   stall                     - freeze PC/pipeline
//   displayValue, outStrobe   - display register and its update pulse
//   waitingInput              - LED: core is blocked on an In
//
// Build option: define IO_PORT_SIGN_EXTEND_EN to sign-extend the switch value
// into inData; by default it is zero-extended.

module io_port_unit #(
  parameter int DATA_WIDTH      = 32,
  parameter int SWITCH_WIDTH    = 16,
  parameter int DISPLAY_WIDTH   = 16,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [5:0]               opcode,
  input  logic                     halt,
  input  logic [DATA_WIDTH-1:0]    outData,
  input  logic [SWITCH_WIDTH-1:0]  switches,
  input  logic                     enterButton,
  output logic [DATA_WIDTH-1:0]    inData,
  output logic                     inWrite,
  output logic                     stall,
  output logic [DISPLAY_WIDTH-1:0] displayValue,
  output logic                     outStrobe,
  output logic                     waitingInput
);

  localparam logic [5:0] OP_IN  = 6'b011011;
  localparam logic [5:0] OP_OUT = 6'b011100;

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_IN = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Button path: synchronizer -> debounce -> rising-edge press pulse
  // ---------------------------------------------------------------------------
  logic             btn_sync1_q, btn_sync2_q;
  logic             btn_acc_q;
  logic [CNT_W-1:0] deb_cnt_q;
  logic             press_q;

  // The counter measures how long the synchronized level has disagreed with the
  // accepted level; any bounce back to agreement restarts the measurement.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      btn_sync1_q <= 1'b0;
      btn_sync2_q <= 1'b0;
      btn_acc_q   <= 1'b0;
      deb_cnt_q   <= '0;
      press_q     <= 1'b0;
    end else begin
      btn_sync1_q <= enterButton;
      btn_sync2_q <= btn_sync1_q;
      press_q     <= 1'b0;
      if (btn_sync2_q == btn_acc_q) begin
        deb_cnt_q <= '0;
      end else if (deb_cnt_q == CNT_LAST) begin
        btn_acc_q <= btn_sync2_q;
        deb_cnt_q <= '0;
        press_q   <= btn_sync2_q;
      end else begin
        deb_cnt_q <= deb_cnt_q + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Switch synchronizer and writeback extension
  // ---------------------------------------------------------------------------
  logic [SWITCH_WIDTH-1:0] sw_sync1_q, sw_sync2_q;
  logic [DATA_WIDTH-1:0]   in_data_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sw_sync1_q <= '0;
      sw_sync2_q <= '0;
    end else begin
      sw_sync1_q <= switches;
      sw_sync2_q <= sw_sync1_q;
    end
  end

  always_comb begin
    in_data_d = DATA_WIDTH'(sw_sync2_q);
`ifdef IO_PORT_SIGN_EXTEND_EN
    for (int i = SWITCH_WIDTH; i < DATA_WIDTH; i++) begin
      in_data_d[i] = sw_sync2_q[SWITCH_WIDTH-1];
    end
`else
`endif
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  state_t                   state_q;
  logic [DATA_WIDTH-1:0]    in_data_q;
  logic                     in_write_q;
  logic                     stall_q;
  logic                     waiting_q;
  logic [DISPLAY_WIDTH-1:0] display_q;
  logic                     out_strobe_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      in_data_q    <= '0;
      in_write_q   <= 1'b0;
      stall_q      <= 1'b0;
      waiting_q    <= 1'b0;
      display_q    <= '0;
      out_strobe_q <= 1'b0;
    end else begin
      in_write_q   <= 1'b0;
      out_strobe_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!halt) begin
            if (opcode == OP_IN) begin
              state_q   <= WAIT_IN;
              stall_q   <= 1'b1;
              waiting_q <= 1'b1;
            end else if (opcode == OP_OUT) begin
              display_q    <= outData[DISPLAY_WIDTH-1:0];
              out_strobe_q <= 1'b1;
            end
          end
        end
        // Only presses generated while here count: a press pulse seen in IDLE
        // is simply dropped, and a button held at entry produces no new pulse.
        WAIT_IN: begin
          if (press_q) begin
            in_data_q  <= in_data_d;
            in_write_q <= 1'b1;
            stall_q    <= 1'b0;
            waiting_q  <= 1'b0;
            state_q    <= CAPTURE;
          end
        end
        CAPTURE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // The decode-cycle term keeps the PC from advancing past an In before the
  // registered stall takes over; it is masked while reset is asserted.
  logic in_decode;
  assign in_decode = reset && (state_q == IDLE) && !halt && (opcode == OP_IN);

  assign stall        = stall_q | in_decode;
  assign inData       = in_data_q;
  assign inWrite      = in_write_q;
  assign displayValue = display_q;
  assign outStrobe    = out_strobe_q;
  assign waitingInput = waiting_q;

  // Upper operand bits above the display width are intentionally ignored.
  logic unused_out_bits;
  assign unused_out_bits = ^outData;

endmodule

// File: tb/tb_io_port_unit.sv
module tb_io_port_unit;

  localparam logic [5:0] OP_IN  = 6'b011011;
  localparam logic [5:0] OP_OUT = 6'b011100;
  localparam logic [5:0] OP_NOP = 6'b000000;

  logic        clock;
  logic        reset;
  logic [5:0]  opcode;
  logic        halt;
  logic [31:0] outData;
  logic [15:0] switches;
  logic        enterButton;
  logic [31:0] inData;
  logic        inWrite;
  logic        stall;
  logic [15:0] displayValue;
  logic        outStrobe;
  logic        waitingInput;

  io_port_unit #(
    .DATA_WIDTH(32), .SWITCH_WIDTH(16), .DISPLAY_WIDTH(16), .DEBOUNCE_CYCLES(4)
  ) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .halt(halt),
    .outData(outData), .switches(switches), .enterButton(enterButton),
    .inData(inData), .inWrite(inWrite), .stall(stall),
    .displayValue(displayValue), .outStrobe(outStrobe),
    .waitingInput(waitingInput)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_in[$];
  logic [15:0] exp_disp[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops an expected value whenever the DUT presents a pulse.
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        if (outStrobe) begin
          if (exp_disp.size() == 0) check("outStrobe_unexpected", 32'(outStrobe), 32'd0);
          else check("displayValue", 32'(displayValue), 32'(exp_disp.pop_front()));
        end
        if (inWrite) begin
          if (exp_in.size() == 0) check("inWrite_unexpected", 32'(inWrite), 32'd0);
          else check("inData", inData, exp_in.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic stalled_cycles(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      step();
      check(name, 32'(stall), 32'd1);
      check({name, "_led"}, 32'(waitingInput), 32'd1);
    end
  endtask

  // Waits for the capture cycle, checking the stall/LED while waiting.
  task automatic wait_capture(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      if (inWrite) begin
        seen   = 1'b1;
        opcode = OP_NOP;
        check("stall_in_capture", 32'(stall), 32'd0);
        check("led_in_capture", 32'(waitingInput), 32'd0);
      end else begin
        check("stall_waiting", 32'(stall), 32'd1);
      end
    end
    check("capture_within_budget", 32'(seen), 32'd1);
    step();
    check("inWrite_one_cycle", 32'(inWrite), 32'd0);
    check("stall_after_capture", 32'(stall), 32'd0);
  endtask

  task automatic release_button();
    enterButton = 1'b0;
    repeat (10) step();
  endtask

  initial begin
    logic [31:0] exp_sx;
    reset = 1'b0; opcode = OP_NOP; halt = 1'b0; outData = '0;
    switches = '0; enterButton = 1'b0;
    repeat (3) step();
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_inWrite", 32'(inWrite), 32'd0);
    check("rst_outStrobe", 32'(outStrobe), 32'd0);
    check("rst_waiting", 32'(waitingInput), 32'd0);
    check("rst_inData", inData, 32'd0);
    check("rst_display", 32'(displayValue), 32'd0);
    reset = 1'b1;
    step();

    // Single Out
    opcode = OP_OUT; outData = 32'h0001_ABCD; exp_disp.push_back(16'hABCD);
    #1 check("out_no_stall", 32'(stall), 32'd0);
    step(); opcode = OP_NOP;
    check("out_strobe_high", 32'(outStrobe), 32'd1);
    check("out_display", 32'(displayValue), 32'h0000_ABCD);
    step();
    check("out_strobe_low", 32'(outStrobe), 32'd0);

    // Back-to-back Outs
    opcode = OP_OUT; outData = 32'h0000_1111; exp_disp.push_back(16'h1111);
    step();
    outData = 32'h0000_2222; exp_disp.push_back(16'h2222);
    check("b2b_no_stall", 32'(stall), 32'd0);
    step(); opcode = OP_NOP;
    step();
    check("b2b_final_display", 32'(displayValue), 32'h0000_2222);

    // Clean In
    switches = 16'h00F5;
    repeat (3) step();
    opcode = OP_IN;
    #1 check("in_stall_same_cycle", 32'(stall), 32'd1);
    stalled_cycles(20, "in_wait");
    exp_in.push_back(32'h0000_00F5);
    enterButton = 1'b1;
    wait_capture(20);
    check("in_data_held", inData, 32'h0000_00F5);
    release_button();

    // Bouncy button in WAIT_IN
    switches = 16'h0A5C;
    repeat (3) step();
    opcode = OP_IN;
    step();
    for (int i = 0; i < 5; i++) begin
      enterButton = 1'b1;
      stalled_cycles(2, "bounce");
      enterButton = 1'b0;
      stalled_cycles(2, "bounce");
    end
    exp_in.push_back(32'h0000_0A5C);
    enterButton = 1'b1;
    wait_capture(20);
    release_button();

    // Button already held when In arrives
    switches = 16'h1234;
    enterButton = 1'b1;
    repeat (10) step();
    opcode = OP_IN;
    stalled_cycles(15, "held");
    enterButton = 1'b0;
    stalled_cycles(10, "held_release");
    exp_in.push_back(32'h0000_1234);
    enterButton = 1'b1;
    wait_capture(20);
    release_button();

    // Halt masks In and Out
    halt = 1'b1; opcode = OP_IN;
    #1 check("halt_in_no_stall", 32'(stall), 32'd0);
    repeat (3) step();
    check("halt_no_wait", 32'(waitingInput), 32'd0);
    check("halt_no_stall_later", 32'(stall), 32'd0);
    opcode = OP_OUT; outData = 32'h0000_BEEF;
    repeat (3) step();
    check("halt_display_kept", 32'(displayValue), 32'h0000_2222);
    halt = 1'b0; opcode = OP_NOP;
    step();

    // Extension of a negative switch value
    switches = 16'h8001;
`ifdef IO_PORT_SIGN_EXTEND_EN
    exp_sx = 32'hFFFF_8001;
`else
    exp_sx = 32'h0000_8001;
`endif
    repeat (3) step();
    opcode = OP_IN;
    step();
    exp_in.push_back(exp_sx);
    enterButton = 1'b1;
    wait_capture(20);
    release_button();

    // Reset in the middle of WAIT_IN
    opcode = OP_IN;
    stalled_cycles(5, "pre_reset");
    reset = 1'b0;
    #1;
    check("midrst_stall", 32'(stall), 32'd0);
    check("midrst_waiting", 32'(waitingInput), 32'd0);
    check("midrst_inWrite", 32'(inWrite), 32'd0);
    check("midrst_inData", inData, 32'd0);
    check("midrst_display", 32'(displayValue), 32'd0);
    opcode = OP_NOP;
    step();
    reset = 1'b1;
    repeat (2) step();
    check("post_rst_stall", 32'(stall), 32'd0);
    check("post_rst_inWrite", 32'(inWrite), 32'd0);

    check("pending_in", 32'(exp_in.size()), 32'd0);
    check("pending_disp", 32'(exp_disp.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
